// File: rtl/chord_song_reader.sv
// -----------------------------------------------------------------------------
// chord_song_reader
//
// Walks one song of a song ROM word by word and feeds the chord players.
// Each 16-bit ROM word is either a note to hand to a free player, a wait of
// N beats, or the end-of-song marker. The reader fetches a word, decodes it,
// and then issues the note (one-cycle new_note strobe) or counts beats down.
//
// ROM word layout:
//   [15]    wait_flag
//   [14:9]  note
//   [8:3]   duration (beats)
//   [2:0]   ignored
//   wait_flag=0 with note=0 and duration=0 marks the end of the song.
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   reset            asynchronous active-high reset
//   play             run/pause; while low, state, index and beat counter freeze
//   song             song select; a change mid-song restarts at the new song
//   beat             one-cycle pulse at 1/48 s, consumed only in WAIT
//   player_available at least one downstream note player is free
//   rom_data         ROM read data, valid one cycle after rom_addr
//   rom_addr         {song_latched, word_index}
//   new_note         one-cycle load strobe to the chord players
//   note_to_load     note code, held until the next issue
//   duration_to_load note length in beats, held until the next issue
//   play_enable      play AND NOT song_done
//   song_done        high while the reader sits at the end of a song
// -----------------------------------------------------------------------------
module chord_song_reader #(
  parameter int NOTE_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play,
  input  logic [1:0]             song,
  input  logic                   beat,
  input  logic                   player_available,
  input  logic [15:0]            rom_data,
  output logic [NOTE_ADDR_W+1:0] rom_addr,
  output logic                   new_note,
  output logic [5:0]             note_to_load,
  output logic [5:0]             duration_to_load,
  output logic                   play_enable,
  output logic                   song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t                 state_q,      state_d;
  logic [1:0]             song_q,       song_d;
  logic [NOTE_ADDR_W-1:0] word_index_q, word_index_d;
  logic [5:0]             beat_count_q, beat_count_d;
  logic [5:0]             note_q,       note_d;       // decoded, not yet issued
  logic [5:0]             dur_q,        dur_d;
  logic [5:0]             note_out_d;
  logic [5:0]             dur_out_d;
  logic                   new_note_d;
  // Set once play has been seen low while in DONE; a later rising play then
  // restarts the song from IDLE.
  logic                   seen_low_q,   seen_low_d;

  // ---------------------------------------------------------------------------
  // ROM word fields
  // ---------------------------------------------------------------------------
  logic       wait_flag;
  logic [5:0] word_note;
  logic [5:0] word_dur;
  logic       end_marker;
  logic       unused_rom_bits;

  assign wait_flag       = rom_data[15];
  assign word_note       = rom_data[14:9];
  assign word_dur        = rom_data[8:3];
  assign end_marker      = !wait_flag && (word_note == 6'd0) && (word_dur == 6'd0);
  assign unused_rom_bits = ^rom_data[2:0];

  // ---------------------------------------------------------------------------
  // Helper conditions
  // ---------------------------------------------------------------------------
  logic last_word;
  logic song_changed;
  logic in_song;

  assign last_word    = &word_index_q;
  assign song_changed = (song != song_q);
  // States in which a song change aborts and restarts the walk.
  assign in_song      = (state_q != IDLE) && (state_q != DONE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    song_d       = song_q;
    word_index_d = word_index_q;
    beat_count_d = beat_count_q;
    note_d       = note_q;
    dur_d        = dur_q;
    note_out_d   = note_to_load;
    dur_out_d    = duration_to_load;
    new_note_d   = 1'b0;
    seen_low_d   = seen_low_q;

    if (in_song && song_changed) begin
      // Abort has priority over pause and over a pending issue: restart the
      // walk at word 0 of the new song and drop any strobe this cycle.
      state_d      = FETCH;
      song_d       = song;
      word_index_d = '0;
    end else if (state_q == DONE) begin
      if (!play) begin
        seen_low_d = 1'b1;
      end
      if (song_changed || (seen_low_q && play)) begin
        state_d    = IDLE;
        seen_low_d = 1'b0;
      end
    end else if (play) begin
      unique case (state_q)
        IDLE: begin
          state_d      = FETCH;
          song_d       = song;
          word_index_d = '0;
        end

        // rom_addr is presented here; the word is on rom_data in DECODE.
        FETCH: begin
          state_d = DECODE;
        end

        DECODE: begin
          if (end_marker) begin
            state_d = DONE;
          end else if (!wait_flag) begin
            note_d  = word_note;
            dur_d   = word_dur;
            state_d = ISSUE;
          end else begin
            beat_count_d = word_dur;
            state_d      = WAIT;
          end
        end

        ISSUE: begin
          if (player_available) begin
            new_note_d = 1'b1;
            note_out_d = note_q;
            dur_out_d  = dur_q;
            if (last_word) begin
              state_d = DONE;
            end else begin
              word_index_d = word_index_q + 1'b1;
              state_d      = FETCH;
            end
          end
        end

        WAIT: begin
          // A zero count advances on its own; the beat in that cycle, if
          // any, is not consumed.
          if (beat_count_q == 6'd0) begin
            if (last_word) begin
              state_d = DONE;
            end else begin
              word_index_d = word_index_q + 1'b1;
              state_d      = FETCH;
            end
          end else if (beat) begin
            beat_count_d = beat_count_q - 6'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      song_q           <= '0;
      word_index_q     <= '0;
      beat_count_q     <= '0;
      note_q           <= '0;
      dur_q            <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      new_note         <= 1'b0;
      seen_low_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      song_q           <= song_d;
      word_index_q     <= word_index_d;
      beat_count_q     <= beat_count_d;
      note_q           <= note_d;
      dur_q            <= dur_d;
      note_to_load     <= note_out_d;
      duration_to_load <= dur_out_d;
      new_note         <= new_note_d;
      seen_low_q       <= seen_low_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs derived from state
  // ---------------------------------------------------------------------------
  assign rom_addr    = {song_q, word_index_q};
  assign song_done   = (state_q == DONE);
  assign play_enable = play && !song_done;

endmodule

// File: tb/tb_chord_song_reader.sv
// -----------------------------------------------------------------------------
// tb_chord_song_reader
//
// Directed scenarios with exact cycle expectations, followed by randomized
// songs checked against a word-list model: the model walks the song ROM and
// predicts the ordered list of issued notes and the minimum number of
// accepted beats that must precede each one.
// -----------------------------------------------------------------------------
module tb_chord_song_reader;

  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          play;
  logic [1:0]    song;
  logic          beat;
  logic          player_available;
  logic [15:0]   rom_data;
  logic [AW+1:0] rom_addr;
  logic          new_note;
  logic [5:0]    note_to_load;
  logic [5:0]    duration_to_load;
  logic          play_enable;
  logic          song_done;

  chord_song_reader #(.NOTE_ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .beat             (beat),
    .player_available (player_available),
    .rom_data         (rom_data),
    .rom_addr         (rom_addr),
    .new_note         (new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .play_enable      (play_enable),
    .song_done        (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous song ROM: data valid one cycle after the address.
  logic [15:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------------------------------------------------------------------
  // Checking and bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         beats;
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  exp_t        exp_q[$];
  bit          sb_en       = 1'b0;
  int          beats_since = 0;
  int          nn_count    = 0;
  logic        prev_nn     = 1'b0;
  logic [31:0] max_addr    = 0;
  logic [1:0]  cur_song    = 2'd0;
  logic [5:0]  last_note   = 6'd0;
  logic [5:0]  last_dur    = 6'd0;
  int          issued      = 0;

  function automatic logic [15:0] w_note(input logic [5:0] n, input logic [5:0] d);
    return {1'b0, n, d, 3'b000};
  endfunction

  function automatic logic [15:0] w_wait(input logic [5:0] d);
    return {1'b1, 6'd0, d, 3'b000};
  endfunction

  // Advance one cycle; inputs set before the call are sampled at the coming
  // rising edge, outputs are examined at the following falling edge.
  task automatic step();
    if (beat && play) beats_since++;
    @(negedge clk);
    if (new_note) begin
      nn_count++;
      check("strobe_gap", {31'd0, prev_nn}, 32'd0);
      if (sb_en) begin
        check("rnd_song_addr", {30'd0, rom_addr[AW+1:AW]}, {30'd0, cur_song});
        if (exp_q.size() == 0) begin
          check("rnd_extra_note", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rnd_note", {26'd0, note_to_load}, {26'd0, e.note});
          check("rnd_dur", {26'd0, duration_to_load}, {26'd0, e.dur});
          check("rnd_beats_before", {31'd0, beats_since >= e.beats}, 32'd1);
          last_note = e.note;
          last_dur  = e.dur;
          issued++;
        end
        beats_since = 0;
      end
    end
    prev_nn = new_note;
    if ({25'd0, rom_addr} > max_addr) max_addr = {25'd0, rom_addr};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play  = 1'b0;
    beat  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    prev_nn = 1'b0;
  endtask

  task automatic wait_nn(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!new_note && n < budget);
    if (!new_note) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!song_done && n < budget);
    check(tag, {31'd0, song_done}, 32'd1);
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int start;

    reset            = 1'b1;
    play             = 1'b0;
    song             = 2'd0;
    beat             = 1'b0;
    player_available = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

    // ---- Reset state --------------------------------------------------------
    do_reset();
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_new_note", {31'd0, new_note}, 32'd0);
    check("rst_note", {26'd0, note_to_load}, 32'd0);
    check("rst_dur", {26'd0, duration_to_load}, 32'd0);
    check("rst_song_done", {31'd0, song_done}, 32'd0);
    check("rst_play_enable", {31'd0, play_enable}, 32'd0);

    // ---- Scenario 1: one note then end marker ------------------------------
    rom[32] = w_note(6'h15, 6'd12);
    rom[33] = 16'h0000;
    song = 2'd1;
    play = 1'b1;
    start = nn_count;
    step();
    check("s1_first_addr", {25'd0, rom_addr}, 32'h20);
    wait_nn("s1_note", 10, n);
    check("s1_latency", n, 32'd3);
    check("s1_note", {26'd0, note_to_load}, 32'h15);
    check("s1_dur", {26'd0, duration_to_load}, 32'd12);
    check("s1_next_addr", {25'd0, rom_addr}, 32'h21);
    step();
    check("s1_single_strobe", {31'd0, new_note}, 32'd0);
    wait_done("s1_done", 10);
    check("s1_play_enable", {31'd0, play_enable}, 32'd0);
    check("s1_note_held", {26'd0, note_to_load}, 32'h15);
    check("s1_count", nn_count - start, 32'd1);
    song = 2'd2;
    step();
    check("s1_song_change_leaves_done", {31'd0, song_done}, 32'd0);

    // ---- Scenario 2: waits of 3 beats and of 0 beats ------------------------
    rom[64] = w_wait(6'd3);
    rom[65] = w_wait(6'd0);
    rom[66] = w_note(6'd5, 6'd1);
    rom[67] = 16'h0000;
    do_reset();
    song = 2'd2;
    play = 1'b1;
    repeat (3) step();
    repeat (4) step();
    check("s2_no_beat_hold", {25'd0, rom_addr}, 32'h40);
    pulse_beat();
    pulse_beat();
    check("s2_two_beats_hold", {25'd0, rom_addr}, 32'h40);
    beat = 1'b1;
    step();
    beat = 1'b0;
    check("s2_third_beat_hold", {25'd0, rom_addr}, 32'h40);
    step();
    check("s2_fetch_after_3rd", {25'd0, rom_addr}, 32'h41);
    step();
    step();
    check("s2_wait0_in_wait", {25'd0, rom_addr}, 32'h41);
    step();
    check("s2_wait0_no_beat", {25'd0, rom_addr}, 32'h42);
    wait_nn("s2_note", 10, n);
    check("s2_note", {26'd0, note_to_load}, 32'd5);
    wait_done("s2_done", 10);

    // ---- Scenario 3: player busy, then a rest; restart via play toggle -------
    rom[0] = w_note(6'h2A, 6'd7);
    rom[1] = w_note(6'd0, 6'd4);
    rom[2] = 16'h0000;
    do_reset();
    song             = 2'd0;
    player_available = 1'b0;
    play             = 1'b1;
    repeat (3) step();
    start = nn_count;
    repeat (10) step();
    check("s3_no_strobe_busy", nn_count - start, 32'd0);
    player_available = 1'b1;
    step();
    check("s3_strobe_on_avail", {31'd0, new_note}, 32'd1);
    check("s3_note", {26'd0, note_to_load}, 32'h2A);
    check("s3_dur", {26'd0, duration_to_load}, 32'd7);
    wait_nn("s3_rest", 10, n);
    check("s3_rest_note", {26'd0, note_to_load}, 32'd0);
    check("s3_rest_dur", {26'd0, duration_to_load}, 32'd4);
    wait_done("s3_done", 10);
    play = 1'b0;
    step();
    check("s3_done_while_low", {31'd0, song_done}, 32'd1);
    play = 1'b1;
    step();
    check("s3_rise_leaves_done", {31'd0, song_done}, 32'd0);
    check("s3_play_enable", {31'd0, play_enable}, 32'd1);

    // ---- Scenario 4: pause during WAIT with beats arriving ------------------
    rom[96] = w_wait(6'd5);
    rom[97] = w_note(6'h11, 6'd2);
    rom[98] = 16'h0000;
    do_reset();
    song = 2'd3;
    play = 1'b1;
    repeat (3) step();
    pulse_beat();
    pulse_beat();
    play = 1'b0;
    for (int k = 0; k < 6; k++) begin
      beat = (k % 2 == 0);
      step();
    end
    beat = 1'b0;
    check("s4_pause_addr", {25'd0, rom_addr}, 32'h60);
    check("s4_pause_play_enable", {31'd0, play_enable}, 32'd0);
    play = 1'b1;
    step();
    pulse_beat();
    pulse_beat();
    check("s4_resume_hold", {25'd0, rom_addr}, 32'h60);
    beat = 1'b1;
    step();
    beat = 1'b0;
    check("s4_last_beat_hold", {25'd0, rom_addr}, 32'h60);
    step();
    check("s4_advance", {25'd0, rom_addr}, 32'h61);
    wait_nn("s4_note", 10, n);
    check("s4_note", {26'd0, note_to_load}, 32'h11);
    wait_done("s4_done", 10);

    // ---- Scenario 5: 32 words with no end marker -----------------------------
    for (int i = 0; i < 32; i++)
      rom[32 + i] = (i % 2 == 0) ? w_note(6'(i + 1), 6'd2) : w_wait(6'd0);
    rom[64] = w_note(6'h3F, 6'd1);
    do_reset();
    song     = 2'd1;
    play     = 1'b1;
    max_addr = 0;
    start    = nn_count;
    wait_done("s5_done", 500);
    check("s5_notes", nn_count - start, 32'd16);
    check("s5_no_wrap", max_addr, 32'h3F);
    check("s5_final_addr", {25'd0, rom_addr}, 32'h3F);

    // ---- Scenario 6: song switch mid-WAIT, reset mid-ISSUE -------------------
    rom[64] = w_wait(6'd20);
    do_reset();
    song = 2'd2;
    play = 1'b1;
    repeat (5) step();
    check("s6_in_wait", {25'd0, rom_addr}, 32'h40);
    song = 2'd3;
    step();
    check("s6_abort_addr", {25'd0, rom_addr}, 32'h60);
    check("s6_abort_no_strobe", {31'd0, new_note}, 32'd0);

    rom[0] = w_note(6'h2A, 6'd7);
    rom[1] = w_note(6'h33, 6'd9);
    do_reset();
    song             = 2'd0;
    player_available = 1'b1;
    play             = 1'b1;
    wait_nn("s6_first", 10, n);
    player_available = 1'b0;
    step();
    step();
    player_available = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("s6_rst_new_note", {31'd0, new_note}, 32'd0);
    check("s6_rst_note", {26'd0, note_to_load}, 32'd0);
    check("s6_rst_dur", {26'd0, duration_to_load}, 32'd0);
    check("s6_rst_addr", {25'd0, rom_addr}, 32'd0);
    check("s6_rst_done", {31'd0, song_done}, 32'd0);
    @(negedge clk);
    check("s6_rst_no_strobe", {31'd0, new_note}, 32'd0);
    reset   = 1'b0;
    prev_nn = 1'b0;

    // ---- Randomized songs against the word-list model -----------------------
    for (int r = 0; r < 8; r++) begin
      int need;
      bit ended;
      cur_song = 2'($urandom_range(0, 3));
      for (int i = 0; i < 32; i++) begin
        int kind;
        logic [5:0] nn;
        logic [5:0] dd;
        kind = $urandom_range(0, 99);
        if (kind < 4 && i >= 4) begin
          rom[cur_song * 32 + i] = 16'($urandom_range(0, 7));
        end else if (kind < 30) begin
          rom[cur_song * 32 + i] = w_wait(6'($urandom_range(0, 3))) | 16'($urandom_range(0, 7));
        end else begin
          nn = 6'($urandom_range(0, 63));
          dd = 6'($urandom_range(0, 63));
          if (nn == 6'd0 && dd == 6'd0) dd = 6'd1;
          rom[cur_song * 32 + i] = w_note(nn, dd) | 16'($urandom_range(0, 7));
        end
      end

      exp_q.delete();
      need  = 0;
      ended = 1'b0;
      for (int i = 0; i < 32 && !ended; i++) begin
        logic [15:0] w;
        w = rom[cur_song * 32 + i];
        if (w[15]) begin
          need += int'(w[8:3]);
        end else if (w[14:3] == 12'd0) begin
          ended = 1'b1;
        end else begin
          exp_t e;
          e.beats = need;
          e.note  = w[14:9];
          e.dur   = w[8:3];
          exp_q.push_back(e);
          need = 0;
        end
      end

      do_reset();
      song        = cur_song;
      beats_since = 0;
      issued      = 0;
      sb_en       = 1'b1;
      n = 0;
      while (!song_done && n < 3000) begin
        play             = ($urandom_range(0, 7) != 0);
        player_available = ($urandom_range(0, 2) != 0);
        beat             = ($urandom_range(0, 2) == 0);
        step();
        n++;
      end
      sb_en = 1'b0;
      beat  = 1'b0;
      check("rnd_done", {31'd0, song_done}, 32'd1);
      check("rnd_all_issued", exp_q.size(), 32'd0);
      if (issued > 0) begin
        check("rnd_note_held", {26'd0, note_to_load}, {26'd0, last_note});
        check("rnd_dur_held", {26'd0, duration_to_load}, {26'd0, last_dur});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
